// File: rtl/rv_pkg.sv
// Shared register-file types and constants for the writeback path.
package rv_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/regfile_writeback_if.sv
// Producer handshakes, register-file write port and forwarding query for the writeback block.
interface regfile_writeback_if
    import rv_pkg::*;
#(
    parameter int DATA_W = rv_pkg::DATA_W,
    parameter int ADDR_W = rv_pkg::ADDR_W,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              alu_valid;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;
    logic              write_enable;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] write_data;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic              fwd_A_valid;
    logic [DATA_W-1:0] fwd_A_data;
    logic              fwd_B_valid;
    logic [DATA_W-1:0] fwd_B_data;
    logic [CNT_W-1:0]  pending;

    modport master (
        output alu_valid, alu_rd, alu_data, input alu_ready,
        output mem_valid, mem_rd, mem_data, input mem_ready,
        input  write_enable, rd, write_data,
        output rs1, rs2,
        input  fwd_A_valid, fwd_A_data, fwd_B_valid, fwd_B_data, pending
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, output alu_ready,
        input  mem_valid, mem_rd, mem_data, output mem_ready,
        output write_enable, rd, write_data,
        input  rs1, rs2,
        output fwd_A_valid, fwd_A_data, fwd_B_valid, fwd_B_data, pending
    );
endinterface

// File: rtl/regfile_writeback_fifo.sv
// In-order writeback queue: up to two pushes and one pop per cycle, with every slot
// exposed so the top level can run the youngest-match forwarding search.
module wb_fifo #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push0,
    input  logic [ADDR_W-1:0]            push0_rd,
    input  logic [DATA_W-1:0]            push0_data,
    input  logic                         push1,
    input  logic [ADDR_W-1:0]            push1_rd,
    input  logic [DATA_W-1:0]            push1_data,
    input  logic                         pop,
    output logic [ADDR_W-1:0]            head_rd,
    output logic [DATA_W-1:0]            head_data,
    output logic [$clog2(DEPTH)-1:0]     head_ptr,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [DEPTH-1:0]             ent_valid,
    output logic [ADDR_W-1:0]            ent_rd   [DEPTH],
    output logic [DATA_W-1:0]            ent_data [DEPTH]
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] rd_mem_q   [DEPTH];
    logic [ADDR_W-1:0] rd_mem_d   [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic [DATA_W-1:0] data_mem_d [DEPTH];
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d, tail1;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     offset;

    always_comb begin
        rd_mem_d   = rd_mem_q;
        data_mem_d = data_mem_q;
        // The second push lands behind the first, or at the tail if only push1 fires.
        tail1 = tail_q + PW'(push0);
        if (push0) begin
            rd_mem_d[tail_q]   = push0_rd;
            data_mem_d[tail_q] = push0_data;
        end
        if (push1) begin
            rd_mem_d[tail1]   = push1_rd;
            data_mem_d[tail1] = push1_data;
        end
        tail_d  = tail1 + PW'(push1);
        head_d  = head_q + PW'(pop);
        count_d = count_q + CW'(push0) + CW'(push1) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        rd_mem_q   <= rd_mem_d;
        data_mem_q <= data_mem_d;
    end

    always_comb begin
        ent_valid = '0;
        offset    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset       = PW'(i) - head_q;
            ent_valid[i] = CW'(offset) < count_q;
        end
    end

    assign ent_rd    = rd_mem_q;
    assign ent_data  = data_mem_q;
    assign head_rd   = rd_mem_q[head_q];
    assign head_data = data_mem_q[head_q];
    assign head_ptr  = head_q;
    assign count     = count_q;
endmodule

// File: rtl/regfile_writeback.sv
// Writeback sequencer: arbitrates ALU/load results into the queue, drops x0 writes,
// retires one write per cycle and forwards pending values to decode.
module regfile_writeback
    import rv_pkg::*;
#(
    parameter int DATA_W = rv_pkg::DATA_W,
    parameter int ADDR_W = rv_pkg::ADDR_W,
    parameter int DEPTH  = 4
) (
    input  logic                clk,
    input  logic                reset,
    regfile_writeback_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int FW = CW + 1;

    logic [CW-1:0]     count;
    logic [PW-1:0]     head_ptr;
    logic [DEPTH-1:0]  ent_valid;
    logic [ADDR_W-1:0] ent_rd   [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];
    logic [ADDR_W-1:0] head_rd;
    logic [DATA_W-1:0] head_data;
    logic              not_empty, we;
    logic              alu_rdy, mem_rdy, alu_push, mem_push;
    logic [FW-1:0]     free, mem_need;
    logic [PW-1:0]     idx;
    logic              fwd_a_v, fwd_b_v;
    logic [DATA_W-1:0] fwd_a_d, fwd_b_d;

    // The head always pops this cycle, so its slot is credited as free.
    always_comb begin
        not_empty = count != '0;
        free      = FW'(DEPTH) - FW'(count) + FW'(not_empty);
        mem_need  = FW'(1) + FW'(bus.alu_valid && bus.alu_rd != REG_ZERO);
        alu_rdy   = !reset && (free >= FW'(1));
        mem_rdy   = !reset && (free >= mem_need);
        alu_push  = bus.alu_valid && alu_rdy && bus.alu_rd != REG_ZERO;
        mem_push  = bus.mem_valid && mem_rdy && bus.mem_rd != REG_ZERO;
        we        = not_empty && !reset;
    end

    wb_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push0      (alu_push),
        .push0_rd   (bus.alu_rd),
        .push0_data (bus.alu_data),
        .push1      (mem_push),
        .push1_rd   (bus.mem_rd),
        .push1_data (bus.mem_data),
        .pop        (not_empty),
        .head_rd    (head_rd),
        .head_data  (head_data),
        .head_ptr   (head_ptr),
        .count      (count),
        .ent_valid  (ent_valid),
        .ent_rd     (ent_rd),
        .ent_data   (ent_data)
    );

    // Walk oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        fwd_a_v = 1'b0;
        fwd_a_d = '0;
        fwd_b_v = 1'b0;
        fwd_b_d = '0;
        idx     = head_ptr;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_ptr + PW'(k);
            if (ent_valid[idx] && !reset) begin
                if (bus.rs1 != REG_ZERO && ent_rd[idx] == bus.rs1) begin
                    fwd_a_v = 1'b1;
                    fwd_a_d = ent_data[idx];
                end
                if (bus.rs2 != REG_ZERO && ent_rd[idx] == bus.rs2) begin
                    fwd_b_v = 1'b1;
                    fwd_b_d = ent_data[idx];
                end
            end
        end
    end

    assign bus.alu_ready    = alu_rdy;
    assign bus.mem_ready    = mem_rdy;
    assign bus.write_enable = we;
    assign bus.rd           = we ? head_rd : '0;
    assign bus.write_data   = we ? head_data : '0;
    assign bus.fwd_A_valid  = fwd_a_v;
    assign bus.fwd_A_data   = fwd_a_d;
    assign bus.fwd_B_valid  = fwd_b_v;
    assign bus.fwd_B_data   = fwd_b_d;
    assign bus.pending      = reset ? '0 : count;
endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Writeback sequencer that drives the write port of the RISC-V register file (`write_enable`, `rd`, `write_data`) and supplies forwarding data for the read port (`rs1`/`rs2` → operand A/B). Two result producers feed it: the ALU and the load unit. Each uses a valid/ready handshake, and the block buffers their results in a small in-order queue. It retires one write per cycle, drops writes to x0, and reports not-yet-written values for any queried source register so decode never reads stale operands.

## Interface
Parameters:
- `DATA_W`, 32: register data width.
- `ADDR_W`, 5: register index width.
- `DEPTH`, 4: queue entries. Must be a power of two, at least 2.

Ports:
- `clk` in 1: the single clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `alu_valid` in 1: ALU result present.
- `alu_rd` in ADDR_W: ALU destination register.
- `alu_data` in DATA_W: ALU result.
- `alu_ready` out 1: ALU result accepted this cycle when high together with `alu_valid`.
- `mem_valid` in 1: load result present.
- `mem_rd` in ADDR_W: load destination register.
- `mem_data` in DATA_W: load data.
- `mem_ready` out 1: load result accepted this cycle when high together with `mem_valid`.
- `write_enable` out 1: register file write strobe.
- `rd` out ADDR_W: register file write index.
- `write_data` out DATA_W: register file write data.
- `rs1` in ADDR_W: decode source register 1.
- `rs2` in ADDR_W: decode source register 2.
- `fwd_A_valid` out 1: a pending write targets `rs1`.
- `fwd_A_data` out DATA_W: value of that pending write.
- `fwd_B_valid` out 1: a pending write targets `rs2`.
- `fwd_B_data` out DATA_W: value of that pending write.
- `pending` out $clog2(DEPTH+1): number of occupied queue entries.

## Operation
- **Queue.** Circular FIFO of {rd, data} entries with head pointer, tail pointer and count.
- **Retire.** The head is presented combinationally. `write_enable` = (count≠0); `rd`/`write_data` = head fields; all three are 0 when empty. The register file always accepts, so a non-empty head pops on every edge.
- **Capacity.** free = DEPTH − count + (count≠0), i.e. the pop in the same cycle is credited.
- **ALU acceptance.** `alu_ready` = (free ≥ 1).
- **Load acceptance.** `mem_ready` = (free ≥ 1 + (alu_valid ∧ alu_rd≠0)). The ALU has priority.
- **Same-cycle enqueue order.** When both are accepted in one cycle, the ALU entry is enqueued first and the load entry second, so the load is younger.
- **x0.** A handshake with rd = 0 completes (ready asserted normally) but nothing is enqueued and the entry consumes no capacity.
- **Forwarding.** All valid entries, including the head, are compared against `rs1` and against `rs2`. The youngest match wins. `rs` = 0 never matches. With no match, valid = 0 and data = 0. Forwarding is purely combinational, from queue state only; inputs that are being handshaken in the current cycle do not forward.
- **WAW.** Entries retire strictly in order, so the register file ends with the youngest value.
- **Reset.** Pointers and count are cleared, `write_enable`/`rd`/`write_data`/forward outputs are 0, `pending` = 0, and both readies are 0 while `reset` is high. A reset mid-operation discards every queued write; none reach the register file.

## Timing
- A result accepted on edge E appears at the head during cycle E+1 (when the queue was empty) with `write_enable` high, and the register file writes it at edge E+1… E+count.
- A forward is visible in the cycle after acceptance and stays visible until the cycle the entry pops. After that pop the register file read returns the value, so there is no gap.
- Throughput: one retire per cycle. Sustained input of two results per cycle fills the queue, then `mem_ready` drops.
- Full queue: count = DEPTH gives free = 1 (credit for the pop). The ALU is accepted and the load stalls if the ALU is also valid.
- Pointers wrap modulo DEPTH. Count never exceeds DEPTH.

## Structure
- Shared package `rv_pkg`:
  - `DATA_W`, `ADDR_W` constants.
  - `wb_entry_t` struct {rd, data}.
  - `REG_ZERO` = 5'd0.
- Sub-module `wb_fifo`: circular buffer with push0/push1 (two pushes per cycle), pop, head output, and a per-entry valid/rd vector for the youngest-match search.
- The top level holds arbitration, the x0 filter and the forwarding priority encoder.

## Test plan
- **Reset, then idle.** `write_enable`=0, `rd`=0, `write_data`=0, `pending`=0, both readies 1 after reset is released.
- **Single ALU write.** alu rd=3, data=8 → next cycle `write_enable`=1, `rd`=3, `write_data`=8, `fwd_A_valid`=1 with rs1=3; the following cycle `pending`=0.
- **Simultaneous ALU and load.** ALU rd=2/5 and load rd=2/7 in the same cycle → retire order 5 then 7; `fwd_B_data`=7 while both are pending, then 7 while only the load remains.
- **x0 drop.** alu rd=0, data=0xDEAD → `alu_ready`=1, `pending` unchanged, `write_enable` stays 0.
- **Backpressure.** Both sources valid every cycle with distinct rd, DEPTH=4 → `mem_ready` falls once full; no loss or reordering across 20 results, checked against a reference model.
- **Reset mid-operation.** 3 entries queued, assert `reset` for 1 cycle → `pending`=0, no `write_enable` pulses for the discarded entries.
